draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_pkg.sv | 38 +++
 rtl/draw_arbiter_if.sv | 32 +++
 rtl/rr_picker.sv | 18 +
 rtl/draw_arbiter.sv | 136 +++++++++++++
 tb/tb_draw_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite draw arbiter.
package draw_pkg;

  // Default visible screen size in pixels.
  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  // Requester indices into req/gnt/done.
  localparam int NUM_REQ = 3;
  localparam int ROCKET  = 0;
  localparam int SHOT    = 1;
  localparam int ALIEN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // (p + k) mod 3, for requester indices 0..2.
  function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // One-hot grant to requester index; defaults to rocket.
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[SHOT])  idx = 2'd1;
    if (oh[ALIEN]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/draw_arbiter_if.sv
// Requester and VGA-side signals of the draw arbiter.
interface draw_arbiter_if;
  logic [2:0] req;
  logic [7:0] reqX0, reqX1, reqX2;
  logic [6:0] reqY0, reqY1, reqY2;
  logic [2:0] reqColour0, reqColour1, reqColour2;
  logic [2:0] reqW0, reqW1, reqW2;
  logic [2:0] reqH0, reqH1, reqH2;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       plot;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColour;
  logic       busy;

  // Arbiter side.
  modport slave (
    input  req, reqX0, reqX1, reqX2, reqY0, reqY1, reqY2,
           reqColour0, reqColour1, reqColour2,
           reqW0, reqW1, reqW2, reqH0, reqH1, reqH2,
    output gnt, done, plot, vgaX, vgaY, vgaColour, busy
  );

  // Requester / environment side.
  modport master (
    output req, reqX0, reqX1, reqX2, reqY0, reqY1, reqY2,
           reqColour0, reqColour1, reqColour2,
           reqW0, reqW1, reqW2, reqH0, reqH1, reqH2,
    input  gnt, done, plot, vgaX, vgaY, vgaColour, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot winner among requesters, search starting at i_ptr.
module rr_picker
  import draw_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt
);

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    o_gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[rr_add(i_ptr, 2'(k))]) o_gnt = 3'b001 << rr_add(i_ptr, 2'(k));
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates three sprite requesters and rasterises the winner's rectangle.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  draw_arbiter_if.slave bus
);

  state_t     r_state, w_state_next;
  logic [1:0] r_ptr;
  logic [2:0] r_win;
  logic [7:0] r_bx;
  logic [6:0] r_by;
  logic [2:0] r_col, r_w, r_h, r_cx, r_cy;

  logic [2:0] w_pick;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_col, w_sel_w, w_sel_h;
  logic [7:0] w_vga_x;
  logic [6:0] w_vga_y;
  logic       w_last_col, w_last_pix;

  rr_picker u_rr_picker (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  assign w_last_col = (r_cx == r_w);
  assign w_last_pix = w_last_col && (r_cy == r_h);
  assign w_vga_x    = r_bx + {5'b0, r_cx};
  assign w_vga_y    = r_by + {4'b0, r_cy};

  // Route the latched winner's sprite description.
  always_comb begin
    w_sel_x   = bus.reqX0;
    w_sel_y   = bus.reqY0;
    w_sel_col = bus.reqColour0;
    w_sel_w   = bus.reqW0;
    w_sel_h   = bus.reqH0;
    case (r_win)
      3'b010: begin
        w_sel_x = bus.reqX1; w_sel_y = bus.reqY1; w_sel_col = bus.reqColour1;
        w_sel_w = bus.reqW1; w_sel_h = bus.reqH1;
      end
      3'b100: begin
        w_sel_x = bus.reqX2; w_sel_y = bus.reqY2; w_sel_col = bus.reqColour2;
        w_sel_w = bus.reqW2; w_sel_h = bus.reqH2;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and outputs; pixel outputs are forced to zero outside DRAW.
  always_comb begin
    w_state_next  = r_state;
    bus.gnt       = '0;
    bus.done      = '0;
    bus.plot      = 1'b0;
    bus.vgaX      = '0;
    bus.vgaY      = '0;
    bus.vgaColour = '0;
    bus.busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: if (|bus.req) w_state_next = ST_LOAD;
      ST_LOAD: begin
        bus.gnt      = r_win;
        w_state_next = ST_DRAW;
      end
      ST_DRAW: begin
        bus.gnt       = r_win;
        bus.vgaX      = w_vga_x;
        bus.vgaY      = w_vga_y;
        bus.vgaColour = r_col;
        bus.plot      = (32'(w_vga_x) < SCREEN_W) && (32'(w_vga_y) < SCREEN_H);
        if (w_last_pix) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done     = r_win;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Winner, sprite latches, raster counters and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      r_win <= '0;
      r_bx  <= '0;
      r_by  <= '0;
      r_col <= '0;
      r_w   <= '0;
      r_h   <= '0;
      r_cx  <= '0;
      r_cy  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (|bus.req) r_win <= w_pick;
        ST_LOAD: begin
          r_bx  <= w_sel_x;
          r_by  <= w_sel_y;
          r_col <= w_sel_col;
          r_w   <= w_sel_w;
          r_h   <= w_sel_h;
          r_cx  <= '0;
          r_cy  <= '0;
        end
        ST_DRAW: begin
          if (w_last_col) begin
            r_cx <= '0;
            r_cy <= r_cy + 3'd1;
          end else begin
            r_cx <= r_cx + 3'd1;
          end
        end
        // Next search starts just past the winner, so it goes to the back of the queue.
        ST_DONE: r_ptr <= rr_add(onehot_to_idx(r_win), 2'd1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed self-checking bench for draw_arbiter.
module tb_draw_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  draw_arbiter_if bus ();

  draw_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_gnt"},  32'(bus.gnt),  0);
    chk({tag, "_plot"}, 32'(bus.plot), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  // Called at the negedge where the FSM sits in LOAD; returns at the DONE negedge.
  task automatic draw_check(input string tag, input logic [2:0] g, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] w, input logic [2:0] h,
                            input logic [2:0] col, input bit drop);
    logic [7:0] ex;
    logic [6:0] ey;
    chk({tag, "_load_gnt"},  32'(bus.gnt),  32'(g));
    chk({tag, "_load_busy"}, 32'(bus.busy), 1);
    chk({tag, "_load_plot"}, 32'(bus.plot), 0);
    for (int r = 0; r <= int'(h); r++) begin
      for (int c = 0; c <= int'(w); c++) begin
        @(negedge clk);
        if (drop && r == 0 && c == 0) bus.req = 3'b000;
        ex = x + 8'(c);
        ey = y + 7'(r);
        chk({tag, "_x"},    32'(bus.vgaX), 32'(ex));
        chk({tag, "_y"},    32'(bus.vgaY), 32'(ey));
        chk({tag, "_col"},  32'(bus.vgaColour), 32'(col));
        chk({tag, "_plot"}, 32'(bus.plot), ((ex < 8'd160) && (ey < 7'd120)) ? 1 : 0);
        chk({tag, "_gnt"},  32'(bus.gnt),  32'(g));
        chk({tag, "_nodone"}, 32'(bus.done), 0);
      end
    end
    @(negedge clk);
    chk({tag, "_done"},      32'(bus.done), 32'(g));
    chk({tag, "_done_gnt"},  32'(bus.gnt),  0);
    chk({tag, "_done_plot"}, 32'(bus.plot), 0);
    chk({tag, "_done_busy"}, 32'(bus.busy), 1);
    $display("draw %s: gnt=%b at (%0d,%0d) size %0dx%0d col=%0d", tag, g, x, y, w + 1, h + 1, col);
  endtask

  task automatic set_req(input int idx, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] w, input logic [2:0] h, input logic [2:0] col);
    case (idx)
      0: begin bus.reqX0 = x; bus.reqY0 = y; bus.reqW0 = w; bus.reqH0 = h; bus.reqColour0 = col; end
      1: begin bus.reqX1 = x; bus.reqY1 = y; bus.reqW1 = w; bus.reqH1 = h; bus.reqColour1 = col; end
      default: begin bus.reqX2 = x; bus.reqY2 = y; bus.reqW2 = w; bus.reqH2 = h; bus.reqColour2 = col; end
    endcase
  endtask

  initial begin
    bus.req = 3'b000;
    set_req(0, 8'd0, 7'd0, 3'd0, 3'd0, 3'd0);
    set_req(1, 8'd0, 7'd0, 3'd0, 3'd0, 3'd0);
    set_req(2, 8'd0, 7'd0, 3'd0, 3'd0, 3'd0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_x", 32'(bus.vgaX), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Continuous 111: rocket, shot, alien, rocket.
    set_req(0, 8'd5, 7'd5, 3'd0, 3'd0, 3'd1);
    set_req(1, 8'd6, 7'd6, 3'd0, 3'd0, 3'd2);
    set_req(2, 8'd7, 7'd7, 3'd0, 3'd0, 3'd3);
    bus.req = 3'b111;
    @(negedge clk); draw_check("rr1_rocket", 3'b001, 8'd5, 7'd5, 3'd0, 3'd0, 3'd1, 1'b0);
    @(negedge clk); chk_idle("rr1_gap");
    @(negedge clk); draw_check("rr2_shot",   3'b010, 8'd6, 7'd6, 3'd0, 3'd0, 3'd2, 1'b0);
    @(negedge clk); chk_idle("rr2_gap");
    @(negedge clk); draw_check("rr3_alien",  3'b100, 8'd7, 7'd7, 3'd0, 3'd0, 3'd3, 1'b0);
    @(negedge clk); chk_idle("rr3_gap");
    @(negedge clk); draw_check("rr4_rocket", 3'b001, 8'd5, 7'd5, 3'd0, 3'd0, 3'd1, 1'b0);
    bus.req = 3'b000;
    @(negedge clk); chk_idle("rr_end");

    // Rocket 2x2 at (10,100).
    set_req(0, 8'd10, 7'd100, 3'd1, 3'd1, 3'd5);
    bus.req = 3'b001;
    @(negedge clk); draw_check("rocket2x2", 3'b001, 8'd10, 7'd100, 3'd1, 3'd1, 3'd5, 1'b1);
    @(negedge clk); chk_idle("rocket2x2_end");

    // Shot at right edge: 158,159 plotted; 160,161 not.
    set_req(1, 8'd158, 7'd0, 3'd3, 3'd0, 3'd6);
    bus.req = 3'b010;
    @(negedge clk); draw_check("shot_edge", 3'b010, 8'd158, 7'd0, 3'd3, 3'd0, 3'd6, 1'b1);
    @(negedge clk); chk_idle("shot_edge_end");

    // Alien erase 3x3 at (50,20); idle two cycles after the last plot.
    set_req(2, 8'd50, 7'd20, 3'd2, 3'd2, 3'd0);
    bus.req = 3'b100;
    @(negedge clk); draw_check("alien_erase", 3'b100, 8'd50, 7'd20, 3'd2, 3'd2, 3'd0, 1'b1);
    @(negedge clk); chk_idle("alien_erase_end");

    // 8x8 rocket crossing the bottom edge, req dropped after LOAD.
    set_req(0, 8'd150, 7'd115, 3'd7, 3'd7, 3'd7);
    bus.req = 3'b001;
    @(negedge clk); draw_check("rocket8x8", 3'b001, 8'd150, 7'd115, 3'd7, 3'd7, 3'd7, 1'b1);
    @(negedge clk); chk_idle("rocket8x8_end");

    // Reset at pixel 5 of an 8x8 draw.
    set_req(0, 8'd20, 7'd30, 3'd7, 3'd7, 3'd4);
    bus.req = 3'b001;
    @(negedge clk);
    chk("abort_load_gnt", 32'(bus.gnt), 32'(3'b001));
    repeat (5) @(negedge clk);
    chk("abort_pix5_x",    32'(bus.vgaX), 24);
    chk("abort_pix5_plot", 32'(bus.plot), 1);
    set_req(0, 8'd1, 7'd2, 3'd1, 3'd0, 3'd3);
    bus.req = 3'b111;
    reset = 1'b0;
    #1;
    chk_idle("abort_now");
    chk("abort_now_x",   32'(bus.vgaX), 0);
    chk("abort_now_y",   32'(bus.vgaY), 0);
    chk("abort_now_col", 32'(bus.vgaColour), 0);
    $display("reset asserted mid-draw");
    repeat (2) begin
      @(negedge clk);
      chk_idle("abort_hold");
    end
    reset = 1'b1;
    @(negedge clk); draw_check("after_reset", 3'b001, 8'd1, 7'd2, 3'd1, 3'd0, 3'd3, 1'b0);
    bus.req = 3'b000;
    @(negedge clk); chk_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
